ex_mem: RTL and testbench
=========================

// Module: ex_mem
// PURPOSE
//  EX->MEM pipeline latch. Registers the EX result (reg write, HI/LO write) into MEM on each clk.
//  Obeys the pipeline stall bus: advance, hold, or inject a bubble.
//  Holds the two-cycle multiply-accumulate scratch state (hilo_tmp, cnt) and feeds it back to EX while EX is stalled.
// PARAMETERS
//  DATA_W   32  width of data, HI and LO (matches `RegBus)
//  RADDR_W  5   register-file address width (matches `RegAddrBus)
//  CNT_W    2   width of the multi-cycle op step counter
// PORTS
//  clk          in   1         rising-edge clock
//  rst          in   1         synchronous, active-high reset (`RstEnable = 1'b1)
//  stall        in   6         pipeline stall bus; bit3 = EX stalled, bit4 = MEM stalled
//  ex_wd        in   RADDR_W   destination register from EX
//  ex_wreg      in   1         register write enable from EX
//  ex_wdata     in   DATA_W    result from EX
//  ex_whilo     in   1         HI/LO write enable from EX
//  ex_hi        in   DATA_W    HI value from EX
//  ex_lo        in   DATA_W    LO value from EX
//  hilo_i       in   2*DATA_W  MADD/MSUB partial product from EX
//  cnt_i        in   CNT_W     MADD/MSUB step count from EX
//  mem_wd       out  RADDR_W   registered ex_wd
//  mem_wreg     out  1         registered ex_wreg
//  mem_wdata    out  DATA_W    registered ex_wdata
//  mem_whilo    out  1         registered ex_whilo
//  mem_hi       out  DATA_W    registered ex_hi
//  mem_lo       out  DATA_W    registered ex_lo
//  hilo_o       out  2*DATA_W  partial product fed back to EX
//  cnt_o        out  CNT_W     step count fed back to EX
// BEHAVIOUR
//  - All outputs are registers and update only on posedge clk. Latency is 1 cycle.
//  - Reset (rst=1 at posedge) forces every output to 0; mem_wreg and mem_whilo = `WriteDisable.
//  - Reset takes priority over stall in every cycle. Reset in the middle of a MADD clears hilo_o and cnt_o, and the op is lost.
//  - Each cycle falls into exactly one mode, chosen by {stall[4], stall[3]}:
//    ADVANCE (stall[3]=0): all mem_* outputs <= the matching ex_* inputs; hilo_o <= 0; cnt_o <= 0.
//    BUBBLE (stall[3]=1, stall[4]=0): all mem_* outputs <= 0, with both write enables disabled; hilo_o <= hilo_i; cnt_o <= cnt_i.
//    HOLD (stall[3]=1, stall[4]=1): mem_* outputs keep their values; hilo_o <= hilo_i; cnt_o <= cnt_i.
//  - stall[3]=0 with stall[4]=1 is illegal, because the stall bus is monotone. The block treats it as ADVANCE; the bench asserts it never happens.
//  - No arithmetic is done here; values pass through bit-exact. cnt_o counts in EX and never wraps here.
//  - A BUBBLE never produces a write: mem_wreg = mem_whilo = 0 in the cycle after it.
// CONFIGURATION
//  EX_MEM_STALL_STAT_EN defined:
//    - Adds output bubble_cnt [31:0], which counts the cycles that were BUBBLE mode.
//    - Adds output hold_cnt [31:0], which counts the cycles that were HOLD mode.
//    - Both counters reset to 0 on rst and wrap modulo 2^32.
//  EX_MEM_STALL_STAT_EN undefined: the ports and counters do not exist, and all other behaviour is identical.
// STRUCTURE
//  - Widths, `RstEnable, `WriteEnable/`WriteDisable, `ZeroWord, `RegBus, `RegAddrBus and `DoubleRegBus come from defines.v.
//  - New define for defines.v: `StallBus (5:0), shared with ctrl and the other pipeline latches.
//  - No sub-module. The optional statistics counters stay inline under `ifdef.
// TESTING
//  1. rst=1 for 2 cycles with random inputs -> all outputs 0. Release rst with stall=0 -> outputs track the inputs 1 cycle later.
//  2. stall=0, ex_wd=5'd3, ex_wreg=1, ex_wdata=32'hDEADBEEF -> next cycle mem_wd=3, mem_wreg=1, mem_wdata=DEADBEEF, and hilo_o=0.
//  3. Previous result latched, then stall=6'b001111 with hilo_i=64'h1_0000_0002 and cnt_i=1 ->
//     next cycle mem_wreg=0, mem_whilo=0, mem_wdata=0, hilo_o=64'h1_0000_0002, cnt_o=1.
//  4. mem_wdata=32'h12345678 latched, then stall=6'b011111 for 3 cycles with new inputs ->
//     mem_* stays 12345678 and unchanged throughout; cnt_o follows cnt_i each cycle.
//  5. ex_whilo=1, ex_hi=32'hA, ex_lo=32'hB with stall=0 -> next cycle mem_whilo=1, mem_hi=A, mem_lo=B.
//     Then assert rst during a stall=6'b001111 cycle -> all outputs 0.
//  6. (EX_MEM_STALL_STAT_EN) 4 BUBBLE cycles and 2 HOLD cycles -> bubble_cnt=4, hold_cnt=2; rst -> both counters 0.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared widths, stall-bus layout and stall-mode decode for the
// EX->MEM pipeline latch and its neighbours on the stall bus.
package ex_mem_pkg;

  localparam int REG_W      = 32;  // data / HI / LO width
  localparam int REG_ADDR_W = 5;   // register-file address width
  localparam int STEP_W     = 2;   // multi-cycle op step counter width
  localparam int STALL_W    = 6;   // pipeline stall bus width
  localparam int STAT_W     = 32;  // stall statistics counter width

  localparam int STALL_EX_BIT  = 3;
  localparam int STALL_MEM_BIT = 4;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    MODE_ADVANCE = 2'd0,
    MODE_BUBBLE  = 2'd1,
    MODE_HOLD    = 2'd2
  } stall_mode_e;

  // EX running means advance; EX stalled with MEM running leaves a hole in
  // MEM (bubble); both stalled freezes MEM. MEM stalled alone cannot occur on
  // a monotone stall bus and is treated as advance.
  function automatic stall_mode_e decode_stall(input logic [STALL_W-1:0] stall);
    stall_mode_e mode;
    if (!stall[STALL_EX_BIT])       mode = MODE_ADVANCE;
    else if (!stall[STALL_MEM_BIT]) mode = MODE_BUBBLE;
    else                            mode = MODE_HOLD;
    return mode;
  endfunction

endpackage

// File: rtl/ex_mem.sv
// ex_mem: EX->MEM pipeline latch. Registers the EX result into MEM, obeys the
// stall bus (advance / bubble / hold) and keeps the MADD/MSUB scratch state
// (partial product and step count) alive while EX is stalled.
// Optional build macro EX_MEM_STALL_STAT_EN adds bubble_cnt / hold_cnt
// counters of bubble and hold cycles.
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int DATA_W  = REG_W,
  parameter int RADDR_W = REG_ADDR_W,
  parameter int CNT_W   = STEP_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STALL_W-1:0]   stall,
  input  logic [RADDR_W-1:0]   ex_wd,
  input  logic                 ex_wreg,
  input  logic [DATA_W-1:0]    ex_wdata,
  input  logic                 ex_whilo,
  input  logic [DATA_W-1:0]    ex_hi,
  input  logic [DATA_W-1:0]    ex_lo,
  input  logic [2*DATA_W-1:0]  hilo_i,
  input  logic [CNT_W-1:0]     cnt_i,
  output logic [RADDR_W-1:0]   mem_wd,
  output logic                 mem_wreg,
  output logic [DATA_W-1:0]    mem_wdata,
  output logic                 mem_whilo,
  output logic [DATA_W-1:0]    mem_hi,
  output logic [DATA_W-1:0]    mem_lo,
  output logic [2*DATA_W-1:0]  hilo_o,
  output logic [CNT_W-1:0]     cnt_o
`ifdef EX_MEM_STALL_STAT_EN
  ,
  output logic [STAT_W-1:0]    bubble_cnt,
  output logic [STAT_W-1:0]    hold_cnt
`endif
);

  stall_mode_e w_mode;

  logic [RADDR_W-1:0]  r_mem_wd;
  logic                r_mem_wreg;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_mem_whilo;
  logic [DATA_W-1:0]   r_mem_hi;
  logic [DATA_W-1:0]   r_mem_lo;
  logic [2*DATA_W-1:0] r_hilo;
  logic [CNT_W-1:0]    r_cnt;

  assign w_mode = decode_stall(stall);

  // MEM-side result latch: pass EX through, insert a non-writing bubble, or freeze.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_wd    <= '0;
      r_mem_wreg  <= WRITE_DISABLE;
      r_mem_wdata <= '0;
      r_mem_whilo <= WRITE_DISABLE;
      r_mem_hi    <= '0;
      r_mem_lo    <= '0;
    end else begin
      unique case (w_mode)
        MODE_ADVANCE: begin
          r_mem_wd    <= ex_wd;
          r_mem_wreg  <= ex_wreg;
          r_mem_wdata <= ex_wdata;
          r_mem_whilo <= ex_whilo;
          r_mem_hi    <= ex_hi;
          r_mem_lo    <= ex_lo;
        end
        MODE_BUBBLE: begin
          r_mem_wd    <= '0;
          r_mem_wreg  <= WRITE_DISABLE;
          r_mem_wdata <= '0;
          r_mem_whilo <= WRITE_DISABLE;
          r_mem_hi    <= '0;
          r_mem_lo    <= '0;
        end
        default: ;  // MODE_HOLD: keep MEM contents
      endcase
    end
  end

  // Multi-cycle scratch: only meaningful while EX is stalled; cleared otherwise
  // so a fresh MADD/MSUB always starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hilo <= '0;
      r_cnt  <= '0;
    end else if (w_mode == MODE_ADVANCE) begin
      r_hilo <= '0;
      r_cnt  <= '0;
    end else begin
      r_hilo <= hilo_i;
      r_cnt  <= cnt_i;
    end
  end

  assign mem_wd    = r_mem_wd;
  assign mem_wreg  = r_mem_wreg;
  assign mem_wdata = r_mem_wdata;
  assign mem_whilo = r_mem_whilo;
  assign mem_hi    = r_mem_hi;
  assign mem_lo    = r_mem_lo;
  assign hilo_o    = r_hilo;
  assign cnt_o     = r_cnt;

`ifdef EX_MEM_STALL_STAT_EN
  logic [STAT_W-1:0] r_bubble_cnt;
  logic [STAT_W-1:0] r_hold_cnt;

  // Stall statistics: free-running, wrapping counts of bubble and hold cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= '0;
      r_hold_cnt   <= '0;
    end else begin
      if (w_mode == MODE_BUBBLE) r_bubble_cnt <= r_bubble_cnt + 1'b1;
      if (w_mode == MODE_HOLD)   r_hold_cnt   <= r_hold_cnt + 1'b1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
  assign hold_cnt   = r_hold_cnt;
`endif

endmodule

// File: tb/tb_ex_mem.sv
// tb_ex_mem: self-checking bench for the EX->MEM pipeline latch.
// Directed vector table plus a model-driven random run, scored through a queue.
module tb_ex_mem;

  typedef struct {
    logic        rst;
    logic [5:0]  stall;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] hilo;
    logic [1:0]  cnt;
  } in_t;

  typedef struct {
    string       name;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] hilo;
    logic [1:0]  cnt;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic        ex_whilo;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;
`ifdef EX_MEM_STALL_STAT_EN
  logic [31:0] bubble_cnt;
  logic [31:0] hold_cnt;
`endif

  int   n_vec  = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  exp_t m;  // reference model state (registered outputs)

  always #5 clk = ~clk;

  ex_mem dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .ex_wd     (ex_wd),
    .ex_wreg   (ex_wreg),
    .ex_wdata  (ex_wdata),
    .ex_whilo  (ex_whilo),
    .ex_hi     (ex_hi),
    .ex_lo     (ex_lo),
    .hilo_i    (hilo_i),
    .cnt_i     (cnt_i),
    .mem_wd    (mem_wd),
    .mem_wreg  (mem_wreg),
    .mem_wdata (mem_wdata),
    .mem_whilo (mem_whilo),
    .mem_hi    (mem_hi),
    .mem_lo    (mem_lo),
    .hilo_o    (hilo_o),
    .cnt_o     (cnt_o)
`ifdef EX_MEM_STALL_STAT_EN
    ,
    .bubble_cnt(bubble_cnt),
    .hold_cnt  (hold_cnt)
`endif
  );

  // The stall bus is monotone: MEM can never be stalled while EX runs.
  always @(posedge clk) begin
    if (rst === 1'b0)
      assert (!(stall[4] && !stall[3]))
      else $error("illegal stall bus value %b", stall);
  end

  task automatic chk(input string name, input string field,
                     input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s got=%h expected=%h", name, field, act, exp);
    end
  endtask

  task automatic drive(input in_t v);
    rst      = v.rst;
    stall    = v.stall;
    ex_wd    = v.wd;
    ex_wreg  = v.wreg;
    ex_wdata = v.wdata;
    ex_whilo = v.whilo;
    ex_hi    = v.hi;
    ex_lo    = v.lo;
    hilo_i   = v.hilo;
    cnt_i    = v.cnt;
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic apply(input in_t v, input exp_t e);
    exp_t x;
    @(negedge clk);
    drive(v);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    chk(x.name, "mem_wd",    64'(mem_wd),    64'(x.wd));
    chk(x.name, "mem_wreg",  64'(mem_wreg),  64'(x.wreg));
    chk(x.name, "mem_wdata", 64'(mem_wdata), 64'(x.wdata));
    chk(x.name, "mem_whilo", 64'(mem_whilo), 64'(x.whilo));
    chk(x.name, "mem_hi",    64'(mem_hi),    64'(x.hi));
    chk(x.name, "mem_lo",    64'(mem_lo),    64'(x.lo));
    chk(x.name, "hilo_o",    hilo_o,         x.hilo);
    chk(x.name, "cnt_o",     64'(cnt_o),     64'(x.cnt));
  endtask

  // Reference behaviour: next registered outputs from the model state and inputs.
  task automatic model_step(input in_t v, input string name, output exp_t e);
    if (v.rst) begin
      m.wd = '0; m.wreg = 1'b0; m.wdata = '0; m.whilo = 1'b0;
      m.hi = '0; m.lo = '0; m.hilo = '0; m.cnt = '0;
    end else if (!v.stall[3]) begin
      m.wd = v.wd; m.wreg = v.wreg; m.wdata = v.wdata; m.whilo = v.whilo;
      m.hi = v.hi; m.lo = v.lo; m.hilo = '0; m.cnt = '0;
    end else begin
      if (!v.stall[4]) begin
        m.wd = '0; m.wreg = 1'b0; m.wdata = '0; m.whilo = 1'b0;
        m.hi = '0; m.lo = '0;
      end
      m.hilo = v.hilo; m.cnt = v.cnt;
    end
    e = m;
    e.name = name;
  endtask

  function automatic in_t rnd_in(input logic r, input logic [5:0] s);
    in_t v;
    v.rst   = r;
    v.stall = s;
    v.wd    = 5'($urandom);
    v.wreg  = 1'($urandom);
    v.wdata = $urandom;
    v.whilo = 1'($urandom);
    v.hi    = $urandom;
    v.lo    = $urandom;
    v.hilo  = {$urandom, $urandom};
    v.cnt   = 2'($urandom);
    return v;
  endfunction

  vec_t tbl[$];

  task automatic add(input in_t i, input exp_t e);
    vec_t t;
    t.i = i;
    t.e = e;
    tbl.push_back(t);
  endtask

  function automatic in_t mk(input logic r, input logic [5:0] s, input logic [4:0] wd,
                             input logic wreg, input logic [31:0] wdata, input logic whilo,
                             input logic [31:0] hi, input logic [31:0] lo,
                             input logic [63:0] hilo, input logic [1:0] cnt);
    in_t v;
    v.rst = r; v.stall = s; v.wd = wd; v.wreg = wreg; v.wdata = wdata;
    v.whilo = whilo; v.hi = hi; v.lo = lo; v.hilo = hilo; v.cnt = cnt;
    return v;
  endfunction

  function automatic exp_t mx(input string n, input logic [4:0] wd, input logic wreg,
                              input logic [31:0] wdata, input logic whilo,
                              input logic [31:0] hi, input logic [31:0] lo,
                              input logic [63:0] hilo, input logic [1:0] cnt);
    exp_t e;
    e.name = n; e.wd = wd; e.wreg = wreg; e.wdata = wdata; e.whilo = whilo;
    e.hi = hi; e.lo = lo; e.hilo = hilo; e.cnt = cnt;
    return e;
  endfunction

  initial begin
    exp_t e;
    in_t  v;
    drive(mk(1'b1, 6'b0, '0, 1'b0, '0, 1'b0, '0, '0, '0, '0));

    // Directed vectors: inputs and hand-derived expected outputs.
    add(rnd_in(1'b1, 6'b001111), mx("rst0", 0, 0, 0, 0, 0, 0, 0, 0));
    add(rnd_in(1'b1, 6'b011111), mx("rst1", 0, 0, 0, 0, 0, 0, 0, 0));
    add(mk(0, 6'b000000, 5'd3, 1, 32'hDEADBEEF, 0, 32'h0, 32'h0, 64'h55, 2'd2),
        mx("adv_wr", 5'd3, 1, 32'hDEADBEEF, 0, 0, 0, 64'h0, 2'd0));
    add(mk(0, 6'b001111, 5'd7, 1, 32'h0000FFFF, 1, 32'h1, 32'h2, 64'h1_0000_0002, 2'd1),
        mx("bubble", 0, 0, 0, 0, 0, 0, 64'h1_0000_0002, 2'd1));
    add(mk(0, 6'b000000, 5'd9, 1, 32'h12345678, 1, 32'h11, 32'h22, 64'hFF, 2'd3),
        mx("adv2", 5'd9, 1, 32'h12345678, 1, 32'h11, 32'h22, 64'h0, 2'd0));
    add(mk(0, 6'b011111, 5'd1, 0, 32'hAAAA5555, 0, 32'h33, 32'h44, 64'h10, 2'd1),
        mx("hold0", 5'd9, 1, 32'h12345678, 1, 32'h11, 32'h22, 64'h10, 2'd1));
    add(mk(0, 6'b011111, 5'd2, 1, 32'h5555AAAA, 1, 32'h55, 32'h66, 64'h20, 2'd2),
        mx("hold1", 5'd9, 1, 32'h12345678, 1, 32'h11, 32'h22, 64'h20, 2'd2));
    add(mk(0, 6'b011111, 5'd4, 0, 32'hFFFFFFFF, 0, 32'h77, 32'h88, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3),
        mx("hold2", 5'd9, 1, 32'h12345678, 1, 32'h11, 32'h22, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3));
    add(mk(0, 6'b000000, 5'd0, 0, 32'h0, 1, 32'hA, 32'hB, 64'h99, 2'd1),
        mx("adv_hilo", 0, 0, 0, 1, 32'hA, 32'hB, 64'h0, 2'd0));
    add(mk(0, 6'b001111, 5'd5, 1, 32'h1, 1, 32'h2, 32'h3, 64'h1234, 2'd1),
        mx("madd_step", 0, 0, 0, 0, 0, 0, 64'h1234, 2'd1));
    add(mk(1, 6'b001111, 5'd6, 1, 32'h4, 1, 32'h5, 32'h6, 64'h5678, 2'd2),
        mx("rst_madd", 0, 0, 0, 0, 0, 0, 64'h0, 2'd0));

    for (int k = 0; k < tbl.size(); k++) apply(tbl[k].i, tbl[k].e);

    // Random legal traffic checked against the reference model; the table
    // ended in reset, so the model starts from all zeros.
    m = mx("", 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 60; k++) begin
      logic [5:0] s;
      case ($urandom_range(0, 2))
        0:       s = 6'b000000;
        1:       s = 6'b001111;
        default: s = 6'b011111;
      endcase
      v = rnd_in(($urandom_range(0, 15) == 0), s);
      model_step(v, $sformatf("rnd%0d", k), e);
      apply(v, e);
    end

`ifdef EX_MEM_STALL_STAT_EN
    v = rnd_in(1'b1, 6'b0);
    model_step(v, "st_rst", e);
    apply(v, e);
    for (int k = 0; k < 4; k++) begin
      v = rnd_in(1'b0, 6'b001111);
      model_step(v, "st_bub", e);
      apply(v, e);
    end
    for (int k = 0; k < 2; k++) begin
      v = rnd_in(1'b0, 6'b011111);
      model_step(v, "st_hold", e);
      apply(v, e);
    end
    v = rnd_in(1'b0, 6'b000000);
    model_step(v, "st_adv", e);
    apply(v, e);
    chk("stat", "bubble_cnt", 64'(bubble_cnt), 64'd4);
    chk("stat", "hold_cnt",   64'(hold_cnt),   64'd2);
    v = rnd_in(1'b1, 6'b011111);
    model_step(v, "st_rst2", e);
    apply(v, e);
    chk("stat_rst", "bubble_cnt", 64'(bubble_cnt), 64'd0);
    chk("stat_rst", "hold_cnt",   64'(hold_cnt),   64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
